// File: rtl/spi_cfg_pkg.sv
// Shared types and register map for the SPI configuration master.
// The address constants name the registers of the receiving slave.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] REG_BACKGROUND_STATE = 8'h00;
  localparam logic [7:0] REG_SOLID_COLOR      = 8'h01;
  localparam logic [7:0] REG_AUDIO_EN         = 8'h02;

  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period tick generator: tick is high on the last clk cycle of each
// CLK_DIV-cycle SCLK phase while enabled; the count restarts when disabled.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int              W    = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0]    LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI write master: sends one {addr,data} frame MSB first, captures MISO,
// then clocks GAP_PULSES idle SCLK pulses with ssel low to resync the slave.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_PULSES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] miso_capt,
  output logic        sclk,
  output logic        ssel,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] LAST_GAP = 5'(GAP_PULSES - 1);

  state_t      state;
  logic [14:0] shreg;   // bits still to send after the one on mosi
  logic [15:0] capt;
  logic [4:0]  bit_cnt;
  logic        tick;
  logic        en;

  assign en        = (state == SHIFT) || (state == GAP);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // NOTE: non-blocking assignments throughout, so sclk is tested and toggled
  // in the same cycle using its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      capt      <= '0;
      bit_cnt   <= '0;
      miso_capt <= '0;
      sclk      <= 1'b0;
      ssel      <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            shreg   <= {req_addr[6:0], req_data};
            capt    <= '0;
            bit_cnt <= '0;
            mosi    <= req_addr[7];
            ssel    <= 1'b1;
            sclk    <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
              capt <= {capt[14:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                ssel    <= 1'b0;
                mosi    <= 1'b0;
                state   <= GAP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                mosi    <= shreg[14];
                shreg   <= {shreg[13:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          if (tick) begin
            sclk <= ~sclk;
            if (sclk) begin
              if (bit_cnt == LAST_GAP) begin
                miso_capt <= capt;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: two instances (CLK_DIV=2 and CLK_DIV=1) checked
// every cycle against a cycle-index model, plus literal expectations.
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

  localparam int G = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, busy, done, sclk, ssel, mosi, miso, inv;
  logic [1:0][7:0]  req_addr, req_data;
  logic [1:0][15:0] miso_capt;

  assign miso = mosi ^ inv;

  spi_cfg_master #(.CLK_DIV(2), .GAP_PULSES(G)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_data(req_data[0]), .busy(busy[0]), .done(done[0]),
    .miso_capt(miso_capt[0]), .sclk(sclk[0]), .ssel(ssel[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_cfg_master #(.CLK_DIV(1), .GAP_PULSES(G)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_data(req_data[1]), .busy(busy[1]), .done(done[1]),
    .miso_capt(miso_capt[1]), .sclk(sclk[1]), .ssel(ssel[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int len_of(input int i);
    return (16 + G) * 2 * div_of(i) + 1;
  endfunction

  // Expected {req_ready,busy,done,sclk,ssel,mosi} in cycle k of a transaction
  // (k=0 idle, k=1 first SHIFT cycle, last k is the DONE cycle).
  function automatic logic [5:0] model_out(input int k, input int d, input logic [15:0] w);
    int ph;
    int b;
    logic [5:0] o;
    o  = 6'b100000;
    ph = (k - 1) % (2 * d);
    b  = (k - 1) / (2 * d);
    if (k == 0)                        o = 6'b100000;
    else if (k <= 32 * d)              o = {1'b0, 1'b1, 1'b0, (ph >= d), 1'b1, w[15 - b]};
    else if (k < (16 + G) * 2 * d + 1) o = {1'b0, 1'b1, 1'b0, (ph >= d), 1'b0, 1'b0};
    else                               o = 6'b011000;
    return o;
  endfunction

  int          k[2]        = '{0, 0};
  logic [15:0] word[2]     = '{16'h0, 16'h0};
  logic [15:0] exp_capt[2] = '{16'h0, 16'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        k[i]        <= 0;
        word[i]     <= '0;
        exp_capt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (k[i] == 0) begin
          if (req_valid[i]) begin
            k[i]    <= 1;
            word[i] <= {req_addr[i], req_data[i]};
          end
        end else if (k[i] == len_of(i)) begin
          k[i] <= 0;
        end else begin
          k[i] <= k[i] + 1;
          if (k[i] == len_of(i) - 1) exp_capt[i] <= word[i] ^ {16{inv[i]}};
        end
      end
    end
  end

  logic [1:0]       prev_sclk = '0;
  logic [1:0][15:0] mseq = '0;
  int               gap_rise[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d k=%0d outputs", i, k[i]),
            32'({req_ready[i], busy[i], done[i], sclk[i], ssel[i], mosi[i]}),
            32'(model_out(k[i], div_of(i), word[i])));
      check($sformatf("dut%0d k=%0d miso_capt", i, k[i]), 32'(miso_capt[i]), 32'(exp_capt[i]));
      if (sclk[i] && !prev_sclk[i]) begin
        if (ssel[i]) mseq[i] <= {mseq[i][14:0], mosi[i]};
        else         gap_rise[i] <= gap_rise[i] + 1;
      end
      prev_sclk[i] <= sclk[i];
    end
  end

  task automatic do_txn(input int i, input logic [7:0] a, input logic [7:0] d, output int lat);
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    req_data[i]  = d;
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    while (!done[i] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int g0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    inv       = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset outputs", 32'({req_ready[0], busy[0], done[0], sclk[0], ssel[0], mosi[0]}), 32'(6'b100000));
    check("reset miso_capt", 32'(miso_capt[0]), 32'h0);

    // Basic write: mosi order, latency, gap pulses
    g0 = gap_rise[0];
    do_txn(0, REG_SOLID_COLOR, 8'h2A, lat);
    check("t1 latency", 32'(lat), 32'd73);
    check("t1 mosi seq", 32'(mseq[0]), 32'h012A);
    check("t1 gap pulses", 32'(gap_rise[0] - g0), 32'd2);

    // Loopback capture
    do_txn(0, 8'hA5, 8'h3C, lat);
    check("t2 miso_capt", 32'(miso_capt[0]), 32'hA53C);

    // Request held across DONE is accepted in the first IDLE cycle
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 8'h10;
    req_data[0]  = 8'h20;
    @(negedge clk);
    lat = 1;
    while (!done[0] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    req_addr[0] = 8'h33;
    req_data[0] = 8'hCC;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 2) req_valid[0] = 1'b0;
      if (done[0]) break;
    end
    check("t3 done spacing", 32'(n), 32'd74);
    check("t3 second capt", 32'(miso_capt[0]), 32'h33CC);
    check("t3 second mosi", 32'(mseq[0]), 32'h33CC);

    // Reset in the 6th bit aborts the frame immediately
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 8'hC3;
    req_data[0]  = 8'h81;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (21) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4 abort pins", 32'({sclk[0], ssel[0], mosi[0], busy[0]}), 32'h0);
    check("t4 abort capt", 32'(miso_capt[0]), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("t4 ready after reset", 32'(req_ready[0]), 32'h1);
    do_txn(0, REG_AUDIO_EN, 8'h01, lat);
    check("t4 post-reset latency", 32'(lat), 32'd73);
    check("t4 post-reset capt", 32'(miso_capt[0]), 32'h0201);

    // CLK_DIV=1 instance; inputs wiggled mid-frame must be ignored
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 8'h96;
    req_data[1]  = 8'h0F;
    @(negedge clk);
    req_valid[1] = 1'b0;
    lat = 1;
    while (!done[1] && lat < 200) begin
      if (lat == 5) begin
        req_addr[1]  = 8'hFF;
        req_data[1]  = 8'h00;
        req_valid[1] = 1'b1;
      end
      if (lat == 10) req_valid[1] = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("t5 latency", 32'(lat), 32'd37);
    check("t5 mosi seq", 32'(mseq[1]), 32'h960F);
    check("t5 miso_capt", 32'(miso_capt[1]), 32'h960F);

    // Inverted miso, CLK_DIV=1
    @(negedge clk);
    inv[1] = 1'b1;
    g0 = gap_rise[1];
    do_txn(1, REG_BACKGROUND_STATE, 8'h96, lat);
    check("t6 miso_capt", 32'(miso_capt[1]), 32'hFF69);
    check("t6 gap pulses", 32'(gap_rise[1] - g0), 32'd2);
    @(negedge clk);
    inv[1] = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, SCLK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter GAP_PULSES, default 2, number of SCLK pulses issued with ssel low after each frame (legal range 1..15).
REQ-003 SHALL have clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have req_valid  input  1  write request present.
REQ-006 SHALL have req_ready  output  1  block can accept a request.
REQ-007 SHALL have req_addr  input  8  register address byte (0 background_state, 1 solid_color, 2 audio_en).
REQ-008 SHALL have req_data  input  8  register data byte.
REQ-009 SHALL have busy  output  1  frame or gap in progress.
REQ-010 SHALL have done  output  1  one-cycle pulse at end of each transaction.
REQ-011 SHALL have miso_capt  output  16  MISO bits sampled during the last frame, first bit in [15].
REQ-012 SHALL have sclk  output  1  SPI clock, idle low.
REQ-013 SHALL have ssel  output  1  slave select, active-high (high = frame in progress).
REQ-014 SHALL have mosi  output  1  serial data out, MSB first.
REQ-015 SHALL have miso  input  1  serial data in.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, GAP, DONE.
REQ-017 IDLE: req_ready=1; on req_valid&&req_ready, latch {req_addr,req_data} into a 16-bit shift register and go to SHIFT.
REQ-018 SHIFT: ssel=1; 16 bit periods of 2*CLK_DIV clk cycles each, sclk low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
REQ-019 mosi SHALL present bit 15 of the latched word from the first SHIFT cycle, and SHALL change only in the cycle sclk goes high->low.
REQ-020 miso SHALL be sampled in the clk cycle sclk goes low->high and shifted into a capture register LSB-first-in (first sample ends in [15]).
REQ-021 After the 16th high phase, sclk SHALL return low, ssel SHALL drop to 0, mosi SHALL go 0, and the FSM SHALL enter GAP.
REQ-022 GAP: ssel=0, mosi=0; issue exactly GAP_PULSES SCLK pulses of the same low/high timing, so the receiver clears its bit/byte counters; then enter DONE.
REQ-023 DONE: one cycle; done=1, miso_capt updated from capture register, sclk=0; next state IDLE.
REQ-024 busy SHALL be 1 in SHIFT, GAP, DONE; req_ready SHALL equal (state==IDLE).
REQ-025 Transaction length SHALL be exactly (16+GAP_PULSES)*2*CLK_DIV+1 cycles from the cycle after the accepting edge through DONE.
REQ-026 Changes on req_valid/req_addr/req_data during a transaction SHALL be ignored; a request held high across DONE SHALL be accepted in the first IDLE cycle.
REQ-027 miso_capt SHALL hold its value between transactions.
REQ-028 Division counter SHALL be $clog2(CLK_DIV+1) bits and bit counter 5 bits; no wrap may occur within legal parameter ranges.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, sclk=0, ssel=0, mosi=0, done=0, busy=0, miso_capt=0, all counters 0.
REQ-030 Reset mid-frame SHALL abort without issuing further sclk edges; req_ready=1 in the first cycle after rst_n rises.

Structure
REQ-031 Package spi_cfg_pkg SHALL hold the FSM state enum and register address constants REG_BACKGROUND_STATE=0, REG_SOLID_COLOR=1, REG_AUDIO_EN=2.
REQ-032 One sub-module spi_sclk_gen SHALL generate half-period ticks (enable, tick output) from CLK_DIV.

Verification
REQ-033 CLK_DIV=2, GAP_PULSES=2: write addr 0x01 data 0x2A -> mosi sequence 0000_0001_0010_1010 on sclk rising edges, done after 73 cycles.
REQ-034 Loopback miso=mosi, addr 0xA5 data 0x3C -> miso_capt=0xA53C.
REQ-035 GAP check -> exactly 2 sclk rising edges with ssel=0 between frames; a back-to-back second request starts in the first IDLE cycle after DONE.
REQ-036 rst_n pulsed after 5th bit -> sclk, ssel, mosi 0 at once; a following write addr 0x02 data 0x01 completes normally.
REQ-037 CLK_DIV=1 -> sclk period 2 clk cycles, done after 37 cycles; req_addr changed mid-frame does not affect mosi.
